// File: rtl/pe_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pe_tile_sequencer
// Purpose  : Loop controller for one PE with double-buffered activation/weight
//            RFs and two psum ports; define PE_TILE_SEQ_PERF_CNT_EN to add the
//            stall_cycles counter output.
// Revision : 1.0 - initial release
// ============================================================================
module pe_tile_sequencer #(
  parameter int ACTV_ADDR_BITWIDTH = 2,
  parameter int WGT_ADDR_BITWIDTH  = 2,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int TILE_BITWIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ACTV_ADDR_BITWIDTH:0]   cfg_k,
  input  logic [PSUM_ADDR_BITWIDTH:0]   cfg_n,
  input  logic [TILE_BITWIDTH-1:0]      cfg_tiles,
  input  logic                          fill_done,
  output logic                          fill_req,
  output logic                          busy,
  output logic                          done,
  output logic                          MAC_en,
  output logic                          actv_sel,
  output logic                          wgt_sel,
  output logic [ACTV_ADDR_BITWIDTH-1:0] actv_r_addr,
  output logic [WGT_ADDR_BITWIDTH-1:0]  wgt_r_addr,
  output logic                          psum_en,
  output logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr,
  output logic [PSUM_ADDR_BITWIDTH-1:0] psum_write_addr
`ifdef PE_TILE_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                   stall_cycles
`endif
);

  localparam int c_KW = ACTV_ADDR_BITWIDTH;
  localparam int c_PW = PSUM_ADDR_BITWIDTH;
  localparam int c_TW = TILE_BITWIDTH;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FILL0 = 3'd1;
  localparam logic [2:0] c_ST_RUN   = 3'd2;
  localparam logic [2:0] c_ST_STALL = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]      r_state, w_state_nxt;
  logic [c_KW:0]   r_cfg_k, w_cfg_k_nxt;
  logic [c_PW:0]   r_cfg_n, w_cfg_n_nxt;
  logic [c_TW-1:0] r_cfg_tiles, w_cfg_tiles_nxt;
  logic [c_KW-1:0] r_k, w_k_nxt;
  logic [c_PW-1:0] r_o, w_o_nxt;
  logic [c_TW-1:0] r_t, w_t_nxt;
  logic            r_next_ready, w_next_ready_nxt;
  logic            r_fill_req, w_fill_req_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_mac_en, w_mac_en_nxt;
  logic            r_sel, w_sel_nxt;
  logic            r_psum_en, w_psum_en_nxt;

  logic w_k_last, w_o_last, w_t_last, w_tile_end, w_have_next, w_swap, w_more_fills;

  assign w_k_last     = ({1'b0, r_k} == r_cfg_k - (c_KW+1)'(1));
  assign w_o_last     = ({1'b0, r_o} == r_cfg_n - (c_PW+1)'(1));
  assign w_t_last     = (r_t == r_cfg_tiles - c_TW'(1));
  assign w_tile_end   = w_k_last & w_o_last;
  assign w_have_next  = r_next_ready | fill_done;
  // Another fill is wanted only if a tile beyond the one being swapped in remains.
  assign w_more_fills = (({1'b0, r_t} + (c_TW+1)'(2)) < {1'b0, r_cfg_tiles});
  assign w_swap       = ((r_state == c_ST_RUN) & w_tile_end & ~w_t_last & w_have_next) |
                        ((r_state == c_ST_STALL) & fill_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_ST_IDLE;
      r_cfg_k      <= '0;
      r_cfg_n      <= '0;
      r_cfg_tiles  <= '0;
      r_k          <= '0;
      r_o          <= '0;
      r_t          <= '0;
      r_next_ready <= 1'b0;
      r_fill_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mac_en     <= 1'b0;
      r_sel        <= 1'b0;
      r_psum_en    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cfg_k      <= w_cfg_k_nxt;
      r_cfg_n      <= w_cfg_n_nxt;
      r_cfg_tiles  <= w_cfg_tiles_nxt;
      r_k          <= w_k_nxt;
      r_o          <= w_o_nxt;
      r_t          <= w_t_nxt;
      r_next_ready <= w_next_ready_nxt;
      r_fill_req   <= w_fill_req_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_mac_en     <= w_mac_en_nxt;
      r_sel        <= w_sel_nxt;
      r_psum_en    <= w_psum_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start) w_state_nxt = c_ST_FILL0;
      c_ST_FILL0: if (fill_done) w_state_nxt = c_ST_RUN;
      c_ST_RUN: begin
        if (w_tile_end) begin
          if (w_t_last)         w_state_nxt = c_ST_DONE;
          else if (!w_have_next) w_state_nxt = c_ST_STALL;
        end
      end
      c_ST_STALL: if (fill_done) w_state_nxt = c_ST_RUN;
      c_ST_DONE:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Next values of every registered output; swaps are applied last so they win.
  always_comb begin
    w_cfg_k_nxt      = r_cfg_k;
    w_cfg_n_nxt      = r_cfg_n;
    w_cfg_tiles_nxt  = r_cfg_tiles;
    w_k_nxt          = r_k;
    w_o_nxt          = r_o;
    w_t_nxt          = r_t;
    w_next_ready_nxt = r_next_ready;
    w_fill_req_nxt   = r_fill_req;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_mac_en_nxt     = r_mac_en;
    w_sel_nxt        = r_sel;
    w_psum_en_nxt    = r_psum_en;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_cfg_k_nxt      = (cfg_k == '0) ? (c_KW+1)'(1) : cfg_k;
          w_cfg_n_nxt      = (cfg_n == '0) ? (c_PW+1)'(1) : cfg_n;
          w_cfg_tiles_nxt  = (cfg_tiles == '0) ? c_TW'(1) : cfg_tiles;
          w_busy_nxt       = 1'b1;
          w_fill_req_nxt   = 1'b1;
          w_next_ready_nxt = 1'b0;
        end
      end
      c_ST_FILL0: begin
        if (fill_done) begin
          w_sel_nxt      = ~r_sel;
          w_k_nxt        = '0;
          w_o_nxt        = '0;
          w_t_nxt        = '0;
          w_mac_en_nxt   = 1'b1;
          w_fill_req_nxt = (r_cfg_tiles > c_TW'(1));
        end
      end
      c_ST_RUN: begin
        if (fill_done) w_next_ready_nxt = 1'b1;
        if (w_tile_end) begin
          if (w_t_last) begin
            w_mac_en_nxt = 1'b0;
            w_done_nxt   = 1'b1;
          end else if (!w_have_next) begin
            w_mac_en_nxt = 1'b0;
          end
        end else if (w_k_last) begin
          w_k_nxt = '0;
          w_o_nxt = r_o + c_PW'(1);
        end else begin
          w_k_nxt = r_k + c_KW'(1);
        end
      end
      c_ST_STALL: if (fill_done) w_mac_en_nxt = 1'b1;
      c_ST_DONE:  w_busy_nxt = 1'b0;
      default: ;
    endcase
    if (w_swap) begin
      w_sel_nxt        = ~r_sel;
      w_psum_en_nxt    = ~r_psum_en;
      w_t_nxt          = r_t + c_TW'(1);
      w_k_nxt          = '0;
      w_o_nxt          = '0;
      w_next_ready_nxt = 1'b0;
      w_fill_req_nxt   = w_more_fills;
    end
  end

  assign fill_req        = r_fill_req;
  assign busy            = r_busy;
  assign done            = r_done;
  assign MAC_en          = r_mac_en;
  assign actv_sel        = r_sel;
  assign wgt_sel         = r_sel;
  assign actv_r_addr     = r_k;
  assign wgt_r_addr      = WGT_ADDR_BITWIDTH'(r_k);
  assign psum_en         = r_psum_en;
  assign psum_addr       = r_o;
  assign psum_write_addr = r_o;

`ifdef PE_TILE_SEQ_PERF_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((r_state == c_ST_IDLE) && start) begin
      r_stall_cycles <= '0;
    end else if (((r_state == c_ST_FILL0) || (r_state == c_ST_STALL)) &&
                 (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
